// File: rtl/mod_n_step_scheduler_pkg.sv
// Shared types and modular-step helper for the mod-N step scheduler.
// Stateless, so no timing or backpressure behaviour of its own.
package mod_n_sched_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} sched_state_t;

    // One modular step of value v in modulus n.
    function automatic logic [31:0] next_mod_n(input logic [31:0] v, input logic up,
                                               input logic [31:0] n);
        if (up)
            return (v == n - 32'd1) ? 32'd0 : v + 32'd1;
        else
            return (v == 32'd0) ? n - 32'd1 : v - 32'd1;
    endfunction

endpackage

// File: rtl/mod_n_step_scheduler_if.sv
// Client-request and shared-counter bundle for the step scheduler.
// Clients hold a request bit until the one-cycle grant pulse comes back.
interface mod_n_step_scheduler_if #(
    parameter int WIDTH   = 2,
    parameter int NUM_REQ = 4,
    parameter int STEP_W  = 4
);
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ-1:0]        i_req_dir;
    logic [NUM_REQ*STEP_W-1:0] i_req_steps;
    logic [NUM_REQ-1:0]        o_gnt;
    logic [NUM_REQ-1:0]        o_done;
    logic                      o_cnt_en;
    logic                      o_cnt_up_dn;
    logic [WIDTH-1:0]          o_cnt_value;
    logic                      o_wrap;
    logic                      o_busy;

    modport master (
        output i_req, i_req_dir, i_req_steps,
        input  o_gnt, o_done, o_cnt_en, o_cnt_up_dn, o_cnt_value, o_wrap, o_busy
    );

    modport slave (
        input  i_req, i_req_dir, i_req_steps,
        output o_gnt, o_done, o_cnt_en, o_cnt_up_dn, o_cnt_value, o_wrap, o_busy
    );
endinterface

// File: rtl/mod_n_step_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping around.
// Purely combinational; no backpressure.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         pick_o,
    output logic                       vld_o
);
    always_comb begin
        pick_o = '0;
        vld_o  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!vld_o && req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
                pick_o[(int'(ptr_i) + i) % NUM_REQ] = 1'b1;
                vld_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mod_n_step_scheduler.sv
// Arbitrates step runs onto one shared mod-N counter; a run occupies steps+3 cycles.
// Losing requesters wait with their request held; at most NUM_REQ-1 runs ahead of them.
module mod_n_step_scheduler #(
    parameter int WIDTH   = 2,
    parameter int N       = 3,
    parameter int NUM_REQ = 4,
    parameter int STEP_W  = 4
) (
    input logic                   i_clk,
    input logic                   i_rst,
    mod_n_step_scheduler_if.slave bus
);
    import mod_n_sched_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               dir_q, dir_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [STEP_W-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               wrap_q, wrap_d;

    logic [NUM_REQ-1:0] pick;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i  (bus.i_req),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .vld_o  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick[i]) pick_idx = IDX_W'(i);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            dir_q   <= 1'b0;
            steps_q <= '0;
            rem_q   <= '0;
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            dir_q   <= dir_d;
            steps_q <= steps_d;
            rem_q   <= rem_d;
            value_q <= value_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        dir_d   = dir_q;
        steps_d = steps_q;
        rem_d   = rem_q;
        value_d = value_q;
        wrap_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    dir_d   = bus.i_req_dir[pick_idx];
                    steps_d = bus.i_req_steps[int'(pick_idx)*STEP_W +: STEP_W];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                rem_d   = steps_q;
                state_d = (steps_q == '0) ? DONE : RUN;
            end
            RUN: begin
                value_d = WIDTH'(next_mod_n(32'(value_q), dir_q, N));
                // Wrap is flagged the cycle after the step that crossed the modulus boundary.
                wrap_d  = dir_q ? (value_q == WIDTH'(N - 1)) : (value_q == '0);
                rem_d   = rem_q - STEP_W'(1);
                if (rem_q == STEP_W'(1)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_gnt       = (state_q == GRANT) ? (NUM_REQ'(1) << owner_q) : '0;
    assign bus.o_done      = (state_q == DONE)  ? (NUM_REQ'(1) << owner_q) : '0;
    assign bus.o_cnt_en    = (state_q == RUN);
    assign bus.o_cnt_up_dn = (state_q == RUN) && dir_q;
    assign bus.o_cnt_value = value_q;
    assign bus.o_wrap      = wrap_q;
    assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mod_n_step_scheduler.sv
// Randomized self-checking bench for mod_n_step_scheduler against a run-level reference model.
module tb_mod_n_step_scheduler;
    localparam int WIDTH = 2, N = 3, NUM_REQ = 4, STEP_W = 4;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    mod_n_step_scheduler_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .STEP_W(STEP_W)) bus ();

    mod_n_step_scheduler #(.WIDTH(WIDTH), .N(N), .NUM_REQ(NUM_REQ), .STEP_W(STEP_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;
    int m_val    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Grant and done must never name two requesters at once.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            check("gnt_onehot", 32'($onehot0(bus.o_gnt)), 32'd1);
            check("done_onehot", 32'($onehot0(bus.o_done)), 32'd1);
        end
    end

    function automatic int pick_winner(input logic [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++)
            if (mask[(m_ptr + i) % NUM_REQ]) return (m_ptr + i) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({bus.o_gnt, bus.o_done, bus.o_cnt_en, bus.o_cnt_up_dn,
                    bus.o_cnt_value, bus.o_wrap, bus.o_busy});
    endfunction

    task automatic set_req(input int k, input int dir, input int steps);
        bus.i_req[k] = 1'b1;
        bus.i_req_dir[k] = dir[0];
        bus.i_req_steps[k*STEP_W +: STEP_W] = STEP_W'(steps);
    endtask

    // Asserted asynchronously between edges; outputs must clear before the next edge.
    task automatic apply_reset(input string tag);
        #2 i_rst = 1'b1;
        #1 check(tag, all_outs(), 32'd0);
        bus.i_req = '0;
        @(negedge i_clk);
        i_rst = 1'b0;
        m_ptr = 0;
        m_val = 0;
    endtask

    // Serve the request the round-robin rule says wins next and check its whole run.
    task automatic expect_run();
        int w, dir, steps, en_cnt, wrap_cnt, exp_wrap, cyc;
        bit got;
        w = pick_winner(bus.i_req);
        check("have_req", 32'(w >= 0), 32'd1);
        if (w < 0) return;
        dir   = int'(bus.i_req_dir[w]);
        steps = int'(bus.i_req_steps[w*STEP_W +: STEP_W]);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge i_clk);
            if (bus.o_gnt != '0) got = 1'b1;
        end
        check("gnt_timeout", 32'(got), 32'd1);
        if (!got) return;
        check("gnt_owner", 32'(bus.o_gnt), 32'(1 << w));
        check("gnt_busy", 32'(bus.o_busy), 32'd1);
        check("gnt_en", 32'(bus.o_cnt_en), 32'd0);
        // Owner drops its request and scrambles its operands; the run must not notice.
        bus.i_req[w] = 1'b0;
        bus.i_req_dir[w] = 1'($urandom);
        bus.i_req_steps[w*STEP_W +: STEP_W] = STEP_W'($urandom);
        if (dir != 0) exp_wrap = (m_val + steps) / N;
        else          exp_wrap = (steps > m_val) ? 1 + (steps - m_val - 1) / N : 0;
        en_cnt = 0;
        wrap_cnt = 0;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge i_clk);
            cyc = c;
            if (bus.o_cnt_en) begin
                check("run_value", 32'(bus.o_cnt_value), 32'(m_val));
                check("run_dir", 32'(bus.o_cnt_up_dn), 32'(dir));
                m_val = (dir != 0) ? (m_val + 1) % N : (m_val + N - 1) % N;
                en_cnt++;
            end
            wrap_cnt += int'(bus.o_wrap);
            if (bus.o_done != '0) break;
        end
        check("done_owner", 32'(bus.o_done), 32'(1 << w));
        check("en_cycles", 32'(en_cnt), 32'(steps));
        check("run_len", 32'(cyc), 32'(steps + 1));
        check("final_value", 32'(bus.o_cnt_value), 32'(m_val));
        check("wrap_count", 32'(wrap_cnt), 32'(exp_wrap));
        m_ptr = (w + 1) % NUM_REQ;
    endtask

    initial begin
        i_rst = 1'b1;
        bus.i_req = '0;
        bus.i_req_dir = '0;
        bus.i_req_steps = '0;
        #12 check("reset_outs", all_outs(), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Up run of 4 from 0: values 1,2,0,1 with one wrap.
        set_req(0, 1, 4);
        expect_run();

        // Idle reset, then a single down step from 0 to N-1.
        apply_reset("reset_idle");
        set_req(2, 0, 1);
        expect_run();

        // Reset in the middle of a long run: no done, pointer back to requester 0.
        set_req(1, 1, 9);
        for (int c = 0; c < 20 && !bus.o_cnt_en; c++) @(negedge i_clk);
        @(negedge i_clk);
        check("midrun_en", 32'(bus.o_cnt_en), 32'd1);
        apply_reset("reset_midrun");
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check("post_reset_quiet", 32'({bus.o_done, bus.o_cnt_en, bus.o_busy}), 32'd0);
        end
        set_req(3, 1, 2);
        set_req(0, 0, 2);
        expect_run();
        expect_run();

        // Zero-step request: grant then done, counter untouched.
        set_req(1, 1, 0);
        expect_run();

        // All four held, one step each: served 0,1,2,3, then a fresh round starts at 0.
        apply_reset("reset_rr");
        for (int k = 0; k < NUM_REQ; k++) set_req(k, k % 2, 1);
        for (int k = 0; k < NUM_REQ; k++) begin
            check("rr_order", 32'(pick_winner(bus.i_req)), 32'(k));
            expect_run();
        end
        set_req(2, 1, 1);
        set_req(0, 1, 1);
        check("rr_fifth", 32'(pick_winner(bus.i_req)), 32'd0);
        expect_run();
        expect_run();

        // Random traffic: newly raised requests get random direction and length.
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (!bus.i_req[k] && $urandom_range(1, 0) == 1)
                    set_req(k, int'($urandom_range(1, 0)), int'($urandom_range(7, 0)));
            if (bus.i_req == '0)
                set_req(int'($urandom_range(NUM_REQ - 1, 0)), int'($urandom_range(1, 0)),
                        int'($urandom_range(7, 0)));
            expect_run();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
